// File: rtl/stage_sequencer_if.sv
// Interface between the LEGv8 stage sequencer and the datapath it controls.
// master = sequencer side, slave = datapath side.
interface stage_sequencer_if #(
   parameter int CNT_W = 32
);
   logic             run;
   logic             halt_req;
   logic             mem_read;
   logic             mem_write;
   logic             reg_write;
   logic             uncondbranch;
   logic             branch;
   logic             zero;
   logic             mem_ready;

   logic             fetch_en;
   logic             decode_en;
   logic             exec_en;
   logic             mem_en;
   logic             wb_en;
   logic             pc_en;
   logic             pc_src;
   logic [2:0]       state;
   logic             busy;
   logic [1:0]       fault;
   logic [CNT_W-1:0] retired_count;

   modport master (
      input  run, halt_req, mem_read, mem_write, reg_write,
             uncondbranch, branch, zero, mem_ready,
      output fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, pc_src,
             state, busy, fault, retired_count
   );

   modport slave (
      output run, halt_req, mem_read, mem_write, reg_write,
             uncondbranch, branch, zero, mem_ready,
      input  fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, pc_src,
             state, busy, fault, retired_count
   );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK phase controller with one-hot stage enables.
// Optional single-step launch control is enabled by defining SEQ_SINGLE_STEP_EN.
module stage_sequencer #(
   parameter int STALL_LIMIT = 15,
   parameter int CNT_W       = 32
) (
   input logic               clk,
   input logic               reset,
`ifdef SEQ_SINGLE_STEP_EN
   input logic               step,
`endif
   stage_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      EXECUTE   = 3'd3,
      MEMORY    = 3'd4,
      WRITEBACK = 3'd5,
      HALTED    = 3'd6
   } state_t;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b10;
   localparam logic [7:0] WAIT_LAST     = 8'(STALL_LIMIT - 1);

   state_t           state_q, state_d;
   logic [1:0]       fault_q, fault_d;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       wait_q;
   logic             halt_q;
   logic             mem_read_q, mem_write_q, reg_write_q, br_q;
   logic             launch;

`ifdef SEQ_SINGLE_STEP_EN
   assign launch = bus.run & step;
`else
   assign launch = bus.run;
`endif

   // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      case (state_q)
         IDLE:    if (launch) state_d = FETCH;
         FETCH:   state_d = DECODE;
         DECODE:  state_d = EXECUTE;
         EXECUTE: begin
            if (bus.mem_read && bus.mem_write) begin
               state_d = HALTED;
               fault_d = FAULT_ILLEGAL;
            end else if (bus.mem_read || bus.mem_write) begin
               state_d = MEMORY;
            end else begin
               state_d = WRITEBACK;
            end
         end
         MEMORY: begin
            // Completion wins over a timeout that would expire on the same cycle.
            if (bus.mem_ready) begin
               state_d = WRITEBACK;
            end else if (wait_q == WAIT_LAST) begin
               state_d = HALTED;
               fault_d = FAULT_TIMEOUT;
            end
         end
         WRITEBACK: begin
`ifdef SEQ_SINGLE_STEP_EN
            state_d = IDLE;
`else
            // halt_req is also looked at directly so a request in this very cycle still stops here.
            if (halt_q || bus.halt_req || !bus.run) state_d = IDLE;
            else                                    state_d = FETCH;
`endif
         end
         HALTED:  state_d = HALTED;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         fault_q     <= FAULT_NONE;
         cnt_q       <= '0;
         wait_q      <= '0;
         halt_q      <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         reg_write_q <= 1'b0;
         br_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;

         if (state_q == EXECUTE) begin
            mem_read_q  <= bus.mem_read;
            mem_write_q <= bus.mem_write;
            reg_write_q <= bus.reg_write;
            br_q        <= bus.uncondbranch | (bus.branch & bus.zero);
            wait_q      <= '0;
         end else if (state_q == MEMORY && !bus.mem_ready) begin
            wait_q <= wait_q + 8'd1;
         end

         if (state_q == WRITEBACK && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);

         if (state_d == IDLE)                        halt_q <= 1'b0;
         else if (state_q != IDLE && bus.halt_req)   halt_q <= 1'b1;
      end
   end

   // Every output below is a function of registered state only.
   assign bus.fetch_en      = (state_q == FETCH);
   assign bus.decode_en     = (state_q == DECODE);
   assign bus.exec_en       = (state_q == EXECUTE);
   assign bus.mem_en        = (state_q == MEMORY) && (mem_read_q || mem_write_q);
   assign bus.pc_en         = (state_q == WRITEBACK);
   assign bus.pc_src        = (state_q == WRITEBACK) && br_q;
   assign bus.wb_en         = (state_q == WRITEBACK) && reg_write_q && !mem_write_q;
   assign bus.state         = state_q;
   assign bus.busy          = (state_q != IDLE) && (state_q != HALTED);
   assign bus.fault         = fault_q;
   assign bus.retired_count = cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: a driver issues instructions and queues predicted
// retire/fault events, an independent monitor pops and compares them as the DUT presents them.
module tb_stage_sequencer;

   localparam int         STALL_LIMIT = 15;
   localparam int         CNT_W       = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_HALTED   = 3'd6;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   stage_sequencer_if #(.CNT_W(CNT_W)) bus ();

   stage_sequencer #(.STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit mr, mw, rw, ub, br, z;
      int n_wait;
      bit halt_dec, halt_wb;
   } instr_t;

   typedef struct {
      bit               is_fault;
      logic [1:0]       fault;
      bit               pc_src;
      bit               wb_en;
      logic [CNT_W-1:0] cnt;
      int               lat;
      int               mem_cycles;
   } exp_t;

   exp_t             sb[$];
   instr_t           pend[$];
   int               total = 0;
   int               bad   = 0;
   logic [CNT_W-1:0] model_cnt = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: outcome of one instruction straight from the architectural rules.
   function automatic exp_t predict(input instr_t i);
      exp_t e;
      e = '{default: 0};
      if (i.mr && i.mw) begin
         e.is_fault = 1; e.fault = 2'b10; e.lat = 3; e.mem_cycles = 0;
      end else if ((i.mr || i.mw) && i.n_wait >= STALL_LIMIT) begin
         e.is_fault = 1; e.fault = 2'b01;
         e.mem_cycles = STALL_LIMIT; e.lat = 3 + STALL_LIMIT;
      end else begin
         e.pc_src = i.ub | (i.br & i.z);
         e.wb_en  = i.rw & ~i.mw;
         if (model_cnt != CNT_MAX) model_cnt = model_cnt + 1'b1;
         e.cnt        = model_cnt;
         e.mem_cycles = (i.mr || i.mw) ? i.n_wait + 1 : 0;
         e.lat        = 3 + e.mem_cycles;
      end
      return e;
   endfunction

   function automatic instr_t mk(input bit mr, mw, rw, ub, br, z, input int n, input bit hd, hw);
      instr_t i;
      i.mr = mr; i.mw = mw; i.rw = rw; i.ub = ub; i.br = br; i.z = z;
      i.n_wait = n; i.halt_dec = hd; i.halt_wb = hw;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      i = '{default: 0};
      case ($urandom_range(0, 4))
         0:       i.rw = 1;
         1:       begin i.mr = 1; i.rw = 1; end
         2:       i.mw = 1;
         3:       i.br = 1;
         default: i.ub = 1;
      endcase
      if ($urandom_range(0, 3) == 0) i.rw = 1;
      i.z      = 1'($urandom_range(0, 1));
      i.n_wait = $urandom_range(0, STALL_LIMIT - 1);
      return i;
   endfunction

   // ---------------- monitor ----------------
   int               cyc = 0, fetch_cyc = 0, mem_cnt = 0;
   bit               halt_seen = 0, cnt_pending = 0;
   logic [CNT_W-1:0] cnt_exp = '0;
   exp_t             mon_e;

   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (cnt_pending) begin
            cnt_pending = 0;
            check("retired_count", bus.retired_count, cnt_exp);
         end
         if (reset) begin
            halt_seen = 0;
            mem_cnt   = 0;
         end else begin
            if (bus.fetch_en) begin fetch_cyc = cyc; mem_cnt = 0; end
            if (bus.mem_en) mem_cnt++;
            if (bus.pc_en || (bus.state == ST_HALTED && !halt_seen)) begin
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_event: state=%0d pc_en=%0d with nothing queued", bus.state, bus.pc_en);
               end else begin
                  mon_e = sb.pop_front();
                  check("event_is_fault", bus.pc_en ? 0 : 1, mon_e.is_fault);
                  check("latency", cyc - fetch_cyc, mon_e.lat);
                  check("mem_en_cycles", mem_cnt, mon_e.mem_cycles);
                  if (mon_e.is_fault) begin
                     check("fault_code", bus.fault, mon_e.fault);
                     check("busy_halted", bus.busy, 0);
                  end else begin
                     check("pc_src", bus.pc_src, mon_e.pc_src);
                     check("wb_en", bus.wb_en, mon_e.wb_en);
                     cnt_exp     = mon_e.cnt;
                     cnt_pending = 1;
                  end
               end
               if (bus.state == ST_HALTED) halt_seen = 1;
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic clear_inputs();
      bus.run = 0; bus.halt_req = 0; bus.mem_read = 0; bus.mem_write = 0;
      bus.reg_write = 0; bus.uncondbranch = 0; bus.branch = 0; bus.zero = 0;
      bus.mem_ready = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      clear_inputs();
      @(negedge clk);
      reset     = 0;
      model_cnt = '0;
   endtask

   // Issues everything in pend; run stays high until the last instruction is fetched
   // (or through it when that instruction carries a halt request).
   task automatic run_batch();
      instr_t cur;
      int     waits, budget;
      bit     done;
      cur = '{default: 0};
      waits = 0; budget = 0; done = 0;
      bus.run = 1;
      while (!done && budget < 2000) begin
         @(negedge clk);
         budget++;
         bus.halt_req = 0;
         if (bus.fetch_en) begin
            if (pend.size() == 0) begin
               total++; bad++;
               $display("FAIL extra_fetch: fetch_en with no instruction pending");
               done = 1;
            end else begin
               cur = pend.pop_front();
               bus.mem_read = cur.mr; bus.mem_write = cur.mw; bus.reg_write = cur.rw;
               bus.uncondbranch = cur.ub; bus.branch = cur.br; bus.zero = cur.z;
               waits = 0;
               sb.push_back(predict(cur));
               if (pend.size() == 0 && !cur.halt_dec && !cur.halt_wb) bus.run = 0;
            end
         end
         if (bus.decode_en && cur.halt_dec) bus.halt_req = 1;
         if (bus.mem_en) begin
            if (waits == cur.n_wait) bus.mem_ready = 1;
            else begin bus.mem_ready = 0; waits++; end
         end else begin
            bus.mem_ready = 1'($urandom_range(0, 1));
         end
         if (bus.state == ST_HALTED) done = 1;
         if (bus.pc_en && pend.size() == 0 && !done) begin
            if (cur.halt_wb) bus.halt_req = 1;
            @(negedge clk);
            bus.halt_req = 0;
            check("post_wb_state", bus.state, ST_IDLE);
            bus.run = 0;
            done = 1;
         end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL batch_timeout: no completion within %0d cycles", budget);
      end
   endtask

   task automatic check_fault_hold(input logic [1:0] f);
      bus.run = 1;
      repeat (4) begin
         @(negedge clk);
         bus.mem_ready = ~bus.mem_ready;
      end
      check("halted_hold_state", bus.state, ST_HALTED);
      check("halted_hold_fault", bus.fault, f);
      check("halted_hold_busy", bus.busy, 0);
      check("halted_mem_en", bus.mem_en, 0);
      do_reset();
      check("post_reset_fault", bus.fault, 2'b00);
      check("post_reset_count", bus.retired_count, 0);
      check("post_reset_state", bus.state, ST_IDLE);
   endtask

   initial begin : main
      int n, budget;
      clear_inputs();
      do_reset();
      check("reset_state", bus.state, ST_IDLE);
      check("reset_fault", bus.fault, 2'b00);
      check("reset_count", bus.retired_count, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_enables", {bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en,
                              bus.wb_en, bus.pc_en, bus.pc_src}, 0);

      repeat (3) @(negedge clk);
      check("idle_without_run", bus.state, ST_IDLE);

      // ADD
      pend.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
      run_batch();
      // LDUR, three stalled cycles
      pend.push_back(mk(1, 0, 1, 0, 0, 0, 3, 0, 0));
      run_batch();
      // CBZ taken, CBZ not taken, B back to back
      pend.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
      pend.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
      pend.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
      run_batch();
      // stall boundary just below the limit, and wait counter restart between accesses
      pend.push_back(mk(0, 1, 1, 0, 0, 0, STALL_LIMIT - 1, 0, 0));
      pend.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
      pend.push_back(mk(1, 0, 1, 0, 0, 0, STALL_LIMIT - 1, 0, 0));
      run_batch();
      // halt requested in DECODE and in WRITEBACK while run stays high
      pend.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
      pend.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0));
      run_batch();
      pend.push_back(mk(1, 0, 1, 0, 0, 0, 2, 0, 1));
      run_batch();

      // random batches, long enough to drive the narrow counter into saturation
      for (int b = 0; b < 8; b++) begin
         int len;
         len = $urandom_range(1, 5);
         for (int k = 0; k < len; k++) pend.push_back(rand_instr());
         run_batch();
      end
      check("count_saturated", bus.retired_count, CNT_MAX);

      // reset in the middle of a memory handshake
      bus.mem_read = 1; bus.mem_write = 0; bus.reg_write = 1;
      bus.uncondbranch = 0; bus.branch = 0; bus.mem_ready = 0; bus.run = 1;
      n = 0; budget = 0;
      while (n < 3 && budget < 50) begin
         @(negedge clk);
         budget++;
         if (bus.fetch_en) bus.run = 0;
         if (bus.mem_en) n++;
      end
      check("mid_mem_reached", n, 3);
      reset = 1;
      @(negedge clk);
      reset = 0;
      clear_inputs();
      model_cnt = '0;
      check("mid_mem_reset_mem_en", bus.mem_en, 0);
      check("mid_mem_reset_state", bus.state, ST_IDLE);
      check("mid_mem_reset_count", bus.retired_count, 0);

      // one instruction before each fault so the reset has a count to clear
      pend.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
      pend.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
      run_batch();
      check_fault_hold(2'b10);

      pend.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
      pend.push_back(mk(0, 1, 0, 0, 0, 0, 255, 0, 0));
      run_batch();
      check_fault_hold(2'b01);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
